mem_lsu: RTL and testbench

- MEM-stage successor to the register/CSR writeback pass-through.
- Registers the EX results and adds a load/store unit for RV32 byte, halfword and word accesses.
- Talks to a data bus over a req/gnt/rvalid handshake, stalls the pipeline while an access is outstanding, and flags misaligned and timed-out accesses.
- Sits between ex_mem and mem_wb.

---
 rtl/mem_lsu.sv | 216 +++++++++++++++++++++
 tb/tb_mem_lsu.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
// MEM stage: registers EX results and runs RV32 byte/half/word loads and stores
// over a req/gnt/rvalid data bus, stalling upstream while an access is in flight.
module mem_lsu #(
    parameter int REG_AW  = 5,
    parameter int CSR_AW  = 12,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [REG_AW-1:0] ex_waddr,
    input  logic [31:0]       ex_wdata,
    input  logic              ex_we,
    input  logic              ex_csr_we,
    input  logic [CSR_AW-1:0] ex_csr_waddr,
    input  logic [31:0]       ex_csr_wdata,
    input  logic              ex_mem_re,
    input  logic              ex_mem_we,
    input  logic [2:0]        ex_mem_op,
    input  logic [31:0]       ex_mem_addr,
    input  logic [31:0]       ex_mem_wdata,
    output logic              dbus_req,
    output logic              dbus_we,
    output logic [31:0]       dbus_addr,
    output logic [3:0]        dbus_be,
    output logic [31:0]       dbus_wdata,
    input  logic              dbus_gnt,
    input  logic              dbus_rvalid,
    input  logic [31:0]       dbus_rdata,
    output logic              stall_req,
    output logic              mem_valid,
    output logic [REG_AW-1:0] mem_waddr,
    output logic [31:0]       mem_wdata,
    output logic              mem_we,
    output logic              mem_csr_we,
    output logic [CSR_AW-1:0] mem_csr_waddr,
    output logic [31:0]       mem_csr_wdata,
    output logic              mem_exc_misalign,
    output logic              mem_exc_fault
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [7:0] TO_LIMIT = 8'(TIMEOUT);

    logic [1:0]        state;
    logic [7:0]        cnt;
    logic [7:0]        cnt_inc;
    logic              timeout_hit;

    // Fields captured at accept time, replayed into mem_* on completion.
    logic [1:0]        a_lsb;
    logic [2:0]        a_op;
    logic              a_load;
    logic [REG_AW-1:0] a_waddr;
    logic [31:0]       a_wdata;
    logic              a_we;
    logic              a_csr_we;
    logic [CSR_AW-1:0] a_csr_waddr;
    logic [31:0]       a_csr_wdata;

    logic              ex_is_mem;
    logic              misalign;
    logic [3:0]        st_be;
    logic [31:0]       st_wdata;
    logic [31:0]       rd_shifted;
    logic [31:0]       ld_data;

    assign ex_is_mem   = ex_mem_re | ex_mem_we;
    assign misalign    = ((ex_mem_op[1:0] == 2'b01) & ex_mem_addr[0]) |
                         (ex_mem_op[1] & (ex_mem_addr[1:0] != 2'b00));
    assign cnt_inc     = cnt + 8'd1;
    assign timeout_hit = (cnt_inc == TO_LIMIT);

    assign dbus_req  = (state == S_REQ);
    assign stall_req = ((state == S_IDLE) & ex_valid & ex_is_mem & ~misalign) |
                       (state == S_REQ) |
                       ((state == S_RESP) & ~dbus_rvalid);

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_mem_wdata;
        case (ex_mem_op[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex_mem_addr[1:0];
                st_wdata = {4{ex_mem_wdata[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << ex_mem_addr[1:0];
                st_wdata = {2{ex_mem_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign rd_shifted = dbus_rdata >> {a_lsb, 3'b000};

    always_comb begin
        ld_data = rd_shifted;
        case (a_op)
            3'b000:  ld_data = {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            3'b100:  ld_data = {24'd0, rd_shifted[7:0]};
            3'b001:  ld_data = {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            3'b101:  ld_data = {16'd0, rd_shifted[15:0]};
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= S_IDLE;
            cnt              <= 8'd0;
            dbus_we          <= 1'b0;
            dbus_addr        <= 32'd0;
            dbus_be          <= 4'd0;
            dbus_wdata       <= 32'd0;
            a_lsb            <= 2'd0;
            a_op             <= 3'd0;
            a_load           <= 1'b0;
            a_waddr          <= '0;
            a_wdata          <= 32'd0;
            a_we             <= 1'b0;
            a_csr_we         <= 1'b0;
            a_csr_waddr      <= '0;
            a_csr_wdata      <= 32'd0;
            mem_valid        <= 1'b0;
            mem_waddr        <= '0;
            mem_wdata        <= 32'd0;
            mem_we           <= 1'b0;
            mem_csr_we       <= 1'b0;
            mem_csr_waddr    <= '0;
            mem_csr_wdata    <= 32'd0;
            mem_exc_misalign <= 1'b0;
            mem_exc_fault    <= 1'b0;
        end else begin
            mem_valid        <= 1'b0;
            mem_exc_misalign <= 1'b0;
            mem_exc_fault    <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (ex_valid) begin
                        if (!ex_is_mem) begin
                            mem_valid     <= 1'b1;
                            mem_waddr     <= ex_waddr;
                            mem_wdata     <= ex_wdata;
                            mem_we        <= ex_we;
                            mem_csr_we    <= ex_csr_we;
                            mem_csr_waddr <= ex_csr_waddr;
                            mem_csr_wdata <= ex_csr_wdata;
                        end else if (misalign) begin
                            mem_valid        <= 1'b1;
                            mem_exc_misalign <= 1'b1;
                            mem_we           <= 1'b0;
                            mem_csr_we       <= 1'b0;
                        end else begin
                            // re and we together is illegal; it degrades to a load.
                            dbus_we     <= ex_mem_we & ~ex_mem_re;
                            dbus_addr   <= {ex_mem_addr[31:2], 2'b00};
                            dbus_be     <= st_be;
                            dbus_wdata  <= st_wdata;
                            a_lsb       <= ex_mem_addr[1:0];
                            a_op        <= ex_mem_op;
                            a_load      <= ex_mem_re;
                            a_waddr     <= ex_waddr;
                            a_wdata     <= ex_wdata;
                            a_we        <= ex_we;
                            a_csr_we    <= ex_csr_we;
                            a_csr_waddr <= ex_csr_waddr;
                            a_csr_wdata <= ex_csr_wdata;
                            cnt         <= 8'd0;
                            state       <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    cnt <= cnt_inc;
                    if (timeout_hit) begin
                        state         <= S_IDLE;
                        mem_valid     <= 1'b1;
                        mem_exc_fault <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_csr_we    <= 1'b0;
                    end else if (dbus_gnt) begin
                        state <= S_RESP;
                    end
                end
                S_RESP: begin
                    cnt <= cnt_inc;
                    if (dbus_rvalid) begin
                        state         <= S_IDLE;
                        mem_valid     <= 1'b1;
                        mem_waddr     <= a_waddr;
                        mem_wdata     <= a_load ? ld_data : a_wdata;
                        mem_we        <= a_we;
                        mem_csr_we    <= a_csr_we;
                        mem_csr_waddr <= a_csr_waddr;
                        mem_csr_wdata <= a_csr_wdata;
                    end else if (timeout_hit) begin
                        state         <= S_IDLE;
                        mem_valid     <= 1'b1;
                        mem_exc_fault <= 1'b1;
                        mem_we        <= 1'b0;
                        mem_csr_we    <= 1'b0;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: scripted bus responses per scenario, with a
// scoreboard of expected MEM results compared whenever mem_valid is seen.
module tb_mem_lsu;

    localparam int TO = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic [4:0]  ex_waddr;
    logic [31:0] ex_wdata;
    logic        ex_we;
    logic        ex_csr_we;
    logic [11:0] ex_csr_waddr;
    logic [31:0] ex_csr_wdata;
    logic        ex_mem_re;
    logic        ex_mem_we;
    logic [2:0]  ex_mem_op;
    logic [31:0] ex_mem_addr;
    logic [31:0] ex_mem_wdata;
    logic        dbus_req;
    logic        dbus_we;
    logic [31:0] dbus_addr;
    logic [3:0]  dbus_be;
    logic [31:0] dbus_wdata;
    logic        dbus_gnt;
    logic        dbus_rvalid;
    logic [31:0] dbus_rdata;
    logic        stall_req;
    logic        mem_valid;
    logic [4:0]  mem_waddr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_csr_we;
    logic [11:0] mem_csr_waddr;
    logic [31:0] mem_csr_wdata;
    logic        mem_exc_misalign;
    logic        mem_exc_fault;

    always #5 clk = ~clk;

    mem_lsu #(.REG_AW(5), .CSR_AW(12), .TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_waddr(ex_waddr), .ex_wdata(ex_wdata), .ex_we(ex_we),
        .ex_csr_we(ex_csr_we), .ex_csr_waddr(ex_csr_waddr), .ex_csr_wdata(ex_csr_wdata),
        .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we), .ex_mem_op(ex_mem_op),
        .ex_mem_addr(ex_mem_addr), .ex_mem_wdata(ex_mem_wdata),
        .dbus_req(dbus_req), .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be),
        .dbus_wdata(dbus_wdata), .dbus_gnt(dbus_gnt), .dbus_rvalid(dbus_rvalid),
        .dbus_rdata(dbus_rdata), .stall_req(stall_req),
        .mem_valid(mem_valid), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_csr_we(mem_csr_we), .mem_csr_waddr(mem_csr_waddr), .mem_csr_wdata(mem_csr_wdata),
        .mem_exc_misalign(mem_exc_misalign), .mem_exc_fault(mem_exc_fault)
    );

    typedef struct {
        bit          chk_data;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        we;
        logic        csr_we;
        logic [11:0] csr_waddr;
        logic [31:0] csr_wdata;
        logic        mis;
        logic        flt;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    // Scoreboard: every completing result must match the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && mem_valid) begin
            tests++;
            if (sb.size() == 0) begin
                fails++;
                $display("FAIL unexpected_mem_valid: got mem_valid=1 with nothing expected (t=%0t)", $time);
            end else begin
                e = sb.pop_front();
                if ({mem_we, mem_csr_we, mem_exc_misalign, mem_exc_fault} !== {e.we, e.csr_we, e.mis, e.flt}) begin
                    fails++;
                    $display("FAIL result_flags: got we/csr_we/mis/flt=%b%b%b%b, expected %b%b%b%b",
                             mem_we, mem_csr_we, mem_exc_misalign, mem_exc_fault, e.we, e.csr_we, e.mis, e.flt);
                end
                if (e.chk_data) begin
                    tests++;
                    if ({mem_waddr, mem_wdata, mem_csr_waddr, mem_csr_wdata} !==
                        {e.waddr, e.wdata, e.csr_waddr, e.csr_wdata}) begin
                        fails++;
                        $display("FAIL result_data: got waddr=%0d wdata=%h csr=%h/%h, expected waddr=%0d wdata=%h csr=%h/%h",
                                 mem_waddr, mem_wdata, mem_csr_waddr, mem_csr_wdata,
                                 e.waddr, e.wdata, e.csr_waddr, e.csr_wdata);
                    end
                end
            end
        end
    end

    task automatic clr_ex();
        ex_valid = 0; ex_waddr = 0; ex_wdata = 0; ex_we = 0;
        ex_csr_we = 0; ex_csr_waddr = 0; ex_csr_wdata = 0;
        ex_mem_re = 0; ex_mem_we = 0; ex_mem_op = 0; ex_mem_addr = 0; ex_mem_wdata = 0;
    endtask

    task automatic drive_ex(input logic re, input logic wm, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] mwdata,
                            input logic [4:0] waddr, input logic [31:0] wdata, input logic we,
                            input logic csr_we, input logic [11:0] caddr, input logic [31:0] cdata);
        ex_valid = 1; ex_mem_re = re; ex_mem_we = wm; ex_mem_op = op;
        ex_mem_addr = addr; ex_mem_wdata = mwdata;
        ex_waddr = waddr; ex_wdata = wdata; ex_we = we;
        ex_csr_we = csr_we; ex_csr_waddr = caddr; ex_csr_wdata = cdata;
    endtask

    task automatic test_reset();
        rst = 1; clr_ex();
        dbus_gnt = 0; dbus_rvalid = 0; dbus_rdata = 0;
        repeat (3) @(negedge clk);
        tests++;
        if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_req, mem_valid, mem_waddr,
             mem_wdata, mem_we, mem_csr_we, mem_csr_waddr, mem_csr_wdata, mem_exc_misalign,
             mem_exc_fault} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got req=%b valid=%b addr=%h wdata=%h, expected all zero",
                     dbus_req, mem_valid, dbus_addr, mem_wdata);
        end
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_passthru();
        drive_ex(0, 0, 3'b000, 32'h0, 32'h0, 5'd5, 32'hDEADBEEF, 1, 1, 12'h305, 32'h0000_0011);
        sb.push_back('{1, 5'd5, 32'hDEADBEEF, 1, 1, 12'h305, 32'h0000_0011, 0, 0});
        #1;
        tests++;
        if (stall_req !== 1'b0) begin
            fails++;
            $display("FAIL passthru_stall: got stall_req=%b, expected 0", stall_req);
        end
        @(negedge clk);
        clr_ex();
        @(negedge clk);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 4; i++) begin
            drive_ex(0, 0, 3'b000, 32'h0, 32'h0, 5'(i + 1), 32'hC0DE_0000 + i, i[0], ~i[0],
                     12'(12'h340 + i), 32'h100 * i);
            sb.push_back('{1, 5'(i + 1), 32'hC0DE_0000 + i, i[0], ~i[0], 12'(12'h340 + i), 32'h100 * i, 0, 0});
            @(negedge clk);
        end
        clr_ex();
        @(negedge clk);
    endtask

    // One aligned access with a scripted bus: gnt after gnt_delay REQ cycles, rvalid next cycle.
    task automatic do_access(input logic is_load, input logic [2:0] op, input logic [31:0] addr,
                             input logic [31:0] swdata, input logic [31:0] rdata, input int gnt_delay,
                             input logic [31:0] exp_ld, input logic [3:0] exp_be, input logic [31:0] exp_dw);
        drive_ex(is_load, ~is_load, op, addr, swdata, 5'd9, 32'h5A5A_5A5A, is_load, 0, 12'h0, 32'h0);
        if (is_load) sb.push_back('{1, 5'd9, exp_ld, 1, 0, 12'h0, 32'h0, 0, 0});
        else         sb.push_back('{0, 5'd9, 32'h0, 0, 0, 12'h0, 32'h0, 0, 0});
        #1;
        tests++;
        if (stall_req !== 1'b1) begin
            fails++;
            $display("FAIL accept_stall: addr=%h got stall_req=%b, expected 1", addr, stall_req);
        end
        @(negedge clk);
        clr_ex();
        for (int i = 0; i <= gnt_delay; i++) begin
            tests++;
            if ({dbus_req, dbus_we, dbus_addr, stall_req} !== {1'b1, ~is_load, {addr[31:2], 2'b00}, 1'b1}) begin
                fails++;
                $display("FAIL req_hold: cycle %0d got req=%b we=%b addr=%h stall=%b, expected 1 %b %h 1",
                         i, dbus_req, dbus_we, dbus_addr, stall_req, ~is_load, {addr[31:2], 2'b00});
            end
            if (!is_load) begin
                tests++;
                if ({dbus_be, dbus_wdata} !== {exp_be, exp_dw}) begin
                    fails++;
                    $display("FAIL store_lanes: cycle %0d got be=%b wdata=%h, expected be=%b wdata=%h",
                             i, dbus_be, dbus_wdata, exp_be, exp_dw);
                end
            end
            if (i == gnt_delay) dbus_gnt = 1;
            @(negedge clk);
            dbus_gnt = 0;
        end
        tests++;
        if ({dbus_req, stall_req} !== 2'b01) begin
            fails++;
            $display("FAIL resp_wait: got req=%b stall=%b, expected req=0 stall=1", dbus_req, stall_req);
        end
        dbus_rvalid = 1; dbus_rdata = rdata;
        #1;
        tests++;
        if (stall_req !== 1'b0) begin
            fails++;
            $display("FAIL rvalid_release: got stall_req=%b, expected 0", stall_req);
        end
        @(negedge clk);
        dbus_rvalid = 0; dbus_rdata = 0;
        @(negedge clk);
    endtask

    task automatic test_loads();
        do_access(1, 3'b000, 32'h0000_1003, 32'h0, 32'h80FF_FF00, 0, 32'hFFFF_FF80, 4'b0, 32'h0);
        do_access(1, 3'b001, 32'h0000_1102, 32'h0, 32'h8001_0000, 1, 32'hFFFF_8001, 4'b0, 32'h0);
        do_access(1, 3'b101, 32'h0000_1102, 32'h0, 32'h8001_0000, 0, 32'h0000_8001, 4'b0, 32'h0);
        do_access(1, 3'b010, 32'h0000_1200, 32'h0, 32'h1234_5678, 2, 32'h1234_5678, 4'b0, 32'h0);
        do_access(1, 3'b000, 32'h0000_1301, 32'h0, 32'h0000_7F00, 0, 32'h0000_007F, 4'b0, 32'h0);
        do_access(1, 3'b100, 32'h0000_1402, 32'h0, 32'h00AB_0000, 0, 32'h0000_00AB, 4'b0, 32'h0);
    endtask

    task automatic test_stores();
        do_access(0, 3'b001, 32'h0000_2002, 32'h1234_ABCD, 32'h0, 3, 32'h0, 4'b1100, 32'hABCD_ABCD);
        do_access(0, 3'b000, 32'h0000_2101, 32'h0000_00EF, 32'h0, 0, 32'h0, 4'b0010, 32'hEFEF_EFEF);
        do_access(0, 3'b010, 32'h0000_2204, 32'hCAFE_F00D, 32'h0, 1, 32'h0, 4'b1111, 32'hCAFE_F00D);
    endtask

    task automatic test_misalign();
        logic [2:0]  ops[4]   = '{3'b010, 3'b001, 3'b101, 3'b010};
        logic [31:0] addrs[4] = '{32'h3001, 32'h3003, 32'h3001, 32'h3002};
        for (int i = 0; i < 4; i++) begin
            drive_ex(i != 3, i == 3, ops[i], addrs[i], 32'hFFFF_FFFF, 5'd3, 32'h1, 1, 1, 12'h7, 32'h2);
            sb.push_back('{0, 5'd0, 32'h0, 0, 0, 12'h0, 32'h0, 1, 0});
            #1;
            tests++;
            if (stall_req !== 1'b0) begin
                fails++;
                $display("FAIL misalign_stall: op=%b addr=%h got stall_req=%b, expected 0", ops[i], addrs[i], stall_req);
            end
            @(negedge clk);
            tests++;
            if (dbus_req !== 1'b0) begin
                fails++;
                $display("FAIL misalign_no_req: op=%b addr=%h got dbus_req=%b, expected 0", ops[i], addrs[i], dbus_req);
            end
        end
        clr_ex();
        @(negedge clk);
    endtask

    task automatic test_timeout();
        drive_ex(1, 0, 3'b010, 32'h0000_0040, 32'h0, 5'd4, 32'h0, 1, 1, 12'h1, 32'h1);
        sb.push_back('{0, 5'd0, 32'h0, 0, 0, 12'h0, 32'h0, 0, 1});
        @(negedge clk);
        clr_ex();
        dbus_gnt = 1;
        @(negedge clk);
        dbus_gnt = 0;
        for (int i = 0; i < TO - 1; i++) begin
            tests++;
            if ({dbus_req, stall_req} !== 2'b01) begin
                fails++;
                $display("FAIL timeout_wait: resp cycle %0d got req=%b stall=%b, expected 0 1", i, dbus_req, stall_req);
            end
            @(negedge clk);
        end
        tests++;
        if ({dbus_req, stall_req, mem_valid} !== 3'b001) begin
            fails++;
            $display("FAIL timeout_exit: got req=%b stall=%b valid=%b, expected 0 0 1", dbus_req, stall_req, mem_valid);
        end
        dbus_rvalid = 1; dbus_rdata = 32'h1111_1111;
        @(negedge clk);
        dbus_rvalid = 0;
        @(negedge clk);
        tests++;
        if (mem_valid !== 1'b0) begin
            fails++;
            $display("FAIL late_rvalid: got mem_valid=%b, expected 0", mem_valid);
        end
    endtask

    task automatic test_reset_mid_access();
        drive_ex(1, 0, 3'b000, 32'h0000_1003, 32'h0, 5'd6, 32'h0, 1, 0, 12'h0, 32'h0);
        @(negedge clk);
        clr_ex();
        dbus_gnt = 1;
        @(negedge clk);
        dbus_gnt = 0;
        rst = 1;
        @(negedge clk);
        tests++;
        if ({dbus_req, dbus_we, dbus_addr, dbus_be, dbus_wdata, stall_req, mem_valid, mem_waddr,
             mem_wdata, mem_we, mem_csr_we, mem_csr_waddr, mem_csr_wdata, mem_exc_misalign,
             mem_exc_fault} !== '0) begin
            fails++;
            $display("FAIL reset_mid_outputs: got req=%b stall=%b addr=%h be=%b, expected all zero",
                     dbus_req, stall_req, dbus_addr, dbus_be);
        end
        rst = 0;
        dbus_rvalid = 1; dbus_rdata = 32'h0000_00FF;
        @(negedge clk);
        dbus_rvalid = 0;
        tests++;
        if ({mem_valid, dbus_req} !== 2'b00) begin
            fails++;
            $display("FAIL reset_stale_rvalid: got valid=%b req=%b, expected 0 0", mem_valid, dbus_req);
        end
        do_access(1, 3'b100, 32'h0000_0010, 32'h0, 32'h0000_0080, 0, 32'h0000_0080, 4'b0, 32'h0);
    endtask

    initial begin
        test_reset();
        test_passthru();
        test_back_to_back();
        test_loads();
        test_stores();
        test_misalign();
        test_timeout();
        test_reset_mid_access();
        repeat (2) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d results never produced, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
